aludec: RTL and testbench

ALUDEC -- requirements
Module: aludec

---
 rtl/aludec.sv | 100 ++++++++++
 tb/tb_aludec.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/aludec.sv
// ---------------------------------------------------------------------------
// aludec -- ALU control decoder with an execute-stage register.
//
// The decoder maps the main-decoder class (aluop) and the instruction fields
// (funct3, funct7b5, opb5) onto a 4-bit ALU control code. The decode is purely
// combinational. A copy of it is also registered for the execute stage. That
// register supports a stall enable and a synchronous reset.
//
// Ports
//   clk          in   1  rising-edge clock
//   reset        in   1  synchronous active-high reset (clears registered outputs)
//   opb5         in   1  opcode bit 5: 1 = R-type, 0 = I-type
//   funct3       in   3  instruction funct3 field
//   funct7b5     in   1  instruction bit 30
//   aluop        in   2  00 load/store, 01 branch, 10 ALU op, 11 reserved
//   en           in   1  register enable, 0 = stall (hold registered outputs)
//   alucontrol   out  4  combinational ALU control code
//   illegal      out  1  combinational unsupported-encoding flag
//   alucontrol_q out  4  registered alucontrol
//   illegal_q    out  1  registered illegal
// ---------------------------------------------------------------------------
module aludec (
    input  logic       clk,
    input  logic       reset,
    input  logic       opb5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [1:0] aluop,
    input  logic       en,
    output logic [3:0] alucontrol,
    output logic       illegal,
    output logic [3:0] alucontrol_q,
    output logic       illegal_q
);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1111;

    logic [3:0] alucontrol_d;
    logic       illegal_d;

    always_comb begin
        alucontrol = ALU_ADD;
        illegal    = 1'b0;
        case (aluop)
            2'b00: alucontrol = ALU_ADD;
            2'b01: alucontrol = ALU_SUB;
            2'b10: begin
                case (funct3)
                    // SUB needs R-type as well: an I-type instruction's bit 30 is
                    // immediate data, so ADDI with a negative immediate stays ADD.
                    3'b000:  alucontrol = (funct7b5 && opb5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alucontrol = ALU_SLL;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b011:  alucontrol = ALU_SLTU;
                    3'b100:  alucontrol = ALU_XOR;
                    // Shift-immediates keep bit 30 as the arithmetic flag, so opb5
                    // is ignored here.
                    3'b101:  alucontrol = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            2'b11: begin
                alucontrol = ALU_ADD;
                illegal    = 1'b1;
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

    always_comb begin
        alucontrol_d = alucontrol_q;
        illegal_d    = illegal_q;
        if (en) begin
            alucontrol_d = alucontrol;
            illegal_d    = illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alucontrol_q <= ALU_ADD;
            illegal_q    <= 1'b0;
        end else begin
            alucontrol_q <= alucontrol_d;
            illegal_q    <= illegal_d;
        end
    end

endmodule

// File: tb/tb_aludec.sv
module tb_aludec;

    logic       clk = 1'b0;
    logic       reset;
    logic       opb5;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [1:0] aluop;
    logic       en;
    logic [3:0] alucontrol;
    logic       illegal;
    logic [3:0] alucontrol_q;
    logic       illegal_q;

    int vectors     = 0;
    int miscompares = 0;

    // Each entry is {illegal, alucontrol}.
    logic [4:0] exp_q[$];
    string      tag_q[$];

    // Reference state of the execute-stage register.
    logic [4:0] ref_reg;

    aludec dut (
        .clk          (clk),
        .reset        (reset),
        .opb5         (opb5),
        .funct3       (funct3),
        .funct7b5     (funct7b5),
        .aluop        (aluop),
        .en           (en),
        .alucontrol   (alucontrol),
        .illegal      (illegal),
        .alucontrol_q (alucontrol_q),
        .illegal_q    (illegal_q)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got illegal=%b ctl=%b, want illegal=%b ctl=%b",
                     tag, obs[4], obs[3:0], exp[4], exp[3:0]);
        end
    endtask

    // Reference decode written from the instruction-set view.
    function automatic logic [4:0] ref_dec(input logic [1:0] op, input logic [2:0] f3,
                                           input logic f7, input logic ob5);
        logic [3:0] c;
        if (op == 2'b00)      return {1'b0, 4'b0000};
        else if (op == 2'b01) return {1'b0, 4'b0001};
        else if (op == 2'b11) return {1'b1, 4'b0000};
        if (f3 == 3'd0)      c = (f7 == 1'b1 && ob5 == 1'b1) ? 4'd1 : 4'd0;
        else if (f3 == 3'd1) c = 4'd4;
        else if (f3 == 3'd2) c = 4'd5;
        else if (f3 == 3'd3) c = 4'd8;
        else if (f3 == 3'd4) c = 4'd6;
        else if (f3 == 3'd5) c = f7 ? 4'd15 : 4'd7;
        else if (f3 == 3'd6) c = 4'd3;
        else                 c = 4'd2;
        return {1'b0, c};
    endfunction

    // Combinational vector: drive, push expected, settle, pop and compare.
    task automatic comb_vec(input string tag, input logic [1:0] op, input logic [2:0] f3,
                            input logic f7, input logic ob5);
        aluop = op; funct3 = f3; funct7b5 = f7; opb5 = ob5;
        exp_q.push_back(ref_dec(op, f3, f7, ob5));
        tag_q.push_back(tag);
        #1;
        check_vec(tag_q.pop_front(), {illegal, alucontrol}, exp_q.pop_front());
    endtask

    // Registered vector: drive at negedge, push expected post-edge value,
    // compare 1 time unit after the rising edge.
    task automatic reg_vec(input string tag, input logic rst, input logic e,
                           input logic [1:0] op, input logic [2:0] f3,
                           input logic f7, input logic ob5);
        @(negedge clk);
        reset = rst; en = e; aluop = op; funct3 = f3; funct7b5 = f7; opb5 = ob5;
        if (rst)    ref_reg = 5'b0;
        else if (e) ref_reg = ref_dec(op, f3, f7, ob5);
        exp_q.push_back(ref_reg);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check_vec(tag_q.pop_front(), {illegal_q, alucontrol_q}, exp_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; en = 1'b0; aluop = 2'b00; funct3 = 3'b000; funct7b5 = 1'b0; opb5 = 1'b0;
        ref_reg = 5'b0;

        // Reset state of the register
        reg_vec("reset_state", 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0);

        // Combinational outputs still decode while reset is held
        @(negedge clk);
        comb_vec("comb_during_reset_sub", 2'b01, 3'b000, 1'b0, 1'b0);
        comb_vec("comb_during_reset_ill", 2'b11, 3'b010, 1'b0, 1'b1);
        reset = 1'b0;

        // Scenario 1: class decodes
        comb_vec("s1_load", 2'b00, 3'b000, 1'b0, 1'b0);
        comb_vec("s1_load_any", 2'b00, 3'b101, 1'b1, 1'b1);
        comb_vec("s1_branch", 2'b01, 3'b000, 1'b0, 1'b0);
        comb_vec("s1_branch_any", 2'b01, 3'b111, 1'b1, 1'b1);
        comb_vec("s1_reserved", 2'b11, 3'b000, 1'b0, 1'b0);

        // Scenario 2: ADD/SUB
        comb_vec("s2_add", 2'b10, 3'b000, 1'b0, 1'b1);
        comb_vec("s2_sub", 2'b10, 3'b000, 1'b1, 1'b1);
        comb_vec("s2_addi_neg", 2'b10, 3'b000, 1'b1, 1'b0);

        // Scenario 3: funct3 sweep
        for (int f = 1; f < 8; f++)
            comb_vec($sformatf("s3_f3_%0d", f), 2'b10, f[2:0], 1'b0, 1'b1);

        // Scenario 4: shifts and AND
        comb_vec("s4_sra", 2'b10, 3'b101, 1'b1, 1'b1);
        comb_vec("s4_srai", 2'b10, 3'b101, 1'b1, 1'b0);
        comb_vec("s4_srli", 2'b10, 3'b101, 1'b0, 1'b0);
        comb_vec("s4_andi", 2'b10, 3'b111, 1'b0, 1'b0);
        comb_vec("s4_and_f7", 2'b10, 3'b111, 1'b1, 1'b1);

        // Exhaustive combinational sweep
        for (int v = 0; v < 64; v++) begin
            logic [5:0] b;
            b = v[5:0];
            comb_vec("sweep", b[5:4], b[3:1], b[0], 1'b0);
            comb_vec("sweep_r", b[5:4], b[3:1], b[0], 1'b1);
        end

        // Scenario 5: registered path
        reg_vec("s5_reset", 1'b1, 1'b1, 2'b01, 3'b000, 1'b0, 1'b0);
        reg_vec("s5_load_sub", 1'b0, 1'b1, 2'b01, 3'b000, 1'b0, 1'b0);
        reg_vec("s5_stall_hold", 1'b0, 1'b0, 2'b11, 3'b000, 1'b0, 1'b0);
        reg_vec("s5_stall_hold2", 1'b0, 1'b0, 2'b11, 3'b000, 1'b0, 1'b0);
        reg_vec("s5_load_illegal", 1'b0, 1'b1, 2'b11, 3'b000, 1'b0, 1'b0);

        // Scenario 6: reset wins over stall
        reg_vec("s6_load_sub", 1'b0, 1'b1, 2'b01, 3'b000, 1'b0, 1'b0);
        reg_vec("s6_reset_stalled", 1'b1, 1'b0, 2'b01, 3'b000, 1'b0, 1'b0);
        reg_vec("s6_first_after_reset", 1'b0, 1'b1, 2'b10, 3'b101, 1'b1, 1'b0);

        // Random registered traffic
        for (int i = 0; i < 60; i++) begin
            logic [7:0] r;
            r = 8'($urandom);
            reg_vec("rand_reg", ($urandom_range(0, 9) == 0), r[7], r[6:5], r[4:2], r[1], r[0]);
        end

        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d left, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
